// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 word demultiplexer: channel count,
// select width and channel indices matching the 4-to-1 mux select encoding.
package demux_pkg;

  localparam int DATA_WIDTH = 18;
  localparam int NUM_CH     = 4;
  localparam int SEL_WIDTH  = 2;

  localparam logic [SEL_WIDTH-1:0] CH_A = 2'd0;
  localparam logic [SEL_WIDTH-1:0] CH_B = 2'd1;
  localparam logic [SEL_WIDTH-1:0] CH_C = 2'd2;
  localparam logic [SEL_WIDTH-1:0] CH_D = 2'd3;

  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_WIDTH-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    onehot = '0;
    case (sel)
      CH_A:    onehot[0] = 1'b1;
      CH_B:    onehot[1] = 1'b1;
      CH_C:    onehot[2] = 1'b1;
      CH_D:    onehot[3] = 1'b1;
      default: onehot = '0;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/channel_fifo.sv
// Single-channel register FIFO with a separate occupancy counter; the head
// output is read from registered storage only.
module channel_fifo #(
  parameter  int DATA_WIDTH = 18,
  parameter  int DEPTH      = 2,
  localparam int PW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = cnt;

  // When empty, show the slot just vacated so the last head value is held.
  assign head_data = empty ? mem[rd_ptr - PW'(1)] : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/demux_1_to_4.sv
// Steers one word stream into four independently handshaked channel FIFOs,
// so a stalled consumer only blocks words addressed to its own channel.
module demux_1_to_4
  import demux_pkg::*;
#(
  parameter  int DATA_WIDTH = demux_pkg::DATA_WIDTH,
  parameter  int DEPTH      = 2,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [SEL_WIDTH-1:0]       in_select,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]          out_valid,
  input  logic [NUM_CH-1:0]          out_ready,
  output logic [NUM_CH*LW-1:0]       level
);

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;

  // Ready reflects only the addressed channel, independent of in_valid.
  assign in_ready  = ~full[in_select];
  assign push      = {NUM_CH{in_valid & in_ready}} & sel_decode(in_select);
  assign pop       = out_ready & ~empty;
  assign out_valid = ~empty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    channel_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .push_data(in_data),
      .pop      (pop[i]),
      .head_data(out_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .empty    (empty[i]),
      .full     (full[i]),
      .count    (level[i*LW +: LW])
    );
  end

endmodule

// File: tb/tb_demux_1_to_4.sv
// Directed, table-driven bench for demux_1_to_4 with DEPTH=2; each record
// gives one cycle of inputs and the outputs expected during that cycle.
module tb_demux_1_to_4;

  localparam int DW = 18;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [1:0]    in_select;
  logic          in_valid;
  logic          in_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*LW-1:0] level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          vld;
    logic [1:0]    sel;
    logic [DW-1:0] data;
    logic [3:0]    ordy;
    logic          exp_rdy;
    logic [3:0]    exp_ov;
    logic [7:0]    exp_lvl;
    logic          chk_d;
    logic [1:0]    dch;
    logic [DW-1:0] dval;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  demux_1_to_4 #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_select(in_select),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic vld, logic [1:0] sel, logic [DW-1:0] data,
                              logic [3:0] ordy, logic exp_rdy, logic [3:0] exp_ov,
                              logic [7:0] exp_lvl, logic chk_d, logic [1:0] dch,
                              logic [DW-1:0] dval);
    vec_t v;
    v.vld = vld; v.sel = sel; v.data = data; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_lvl = exp_lvl;
    v.chk_d = chk_d; v.dch = dch; v.dval = dval;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [4*DW-1:0] act,
                     input logic [4*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [DW-1:0] data,
                       input logic [3:0] ordy);
    in_valid  = vld;
    in_select = sel;
    in_data   = data;
    out_ready = ordy;
  endtask

  initial begin
    // Routing with all consumers ready
    vecs[0]  = mk(1, 2'd0, 18'h01234, 4'b1111, 1, 4'b0000, 8'b00_00_00_00, 0, 2'd0, 18'h0);
    vecs[1]  = mk(1, 2'd1, 18'h05678, 4'b1111, 1, 4'b0001, 8'b00_00_00_01, 1, 2'd0, 18'h01234);
    vecs[2]  = mk(1, 2'd2, 18'h09abc, 4'b1111, 1, 4'b0010, 8'b00_00_01_00, 1, 2'd1, 18'h05678);
    vecs[3]  = mk(1, 2'd3, 18'h0def0, 4'b1111, 1, 4'b0100, 8'b00_01_00_00, 1, 2'd2, 18'h09abc);
    vecs[4]  = mk(0, 2'd0, 18'h00000, 4'b1111, 1, 4'b1000, 8'b01_00_00_00, 1, 2'd3, 18'h0def0);
    vecs[5]  = mk(0, 2'd0, 18'h00000, 4'b1111, 1, 4'b0000, 8'b00_00_00_00, 1, 2'd0, 18'h01234);
    // Backpressure on c, fill it
    vecs[6]  = mk(1, 2'd2, 18'h00001, 4'b1011, 1, 4'b0000, 8'b00_00_00_00, 0, 2'd0, 18'h0);
    vecs[7]  = mk(1, 2'd2, 18'h00002, 4'b1011, 1, 4'b0100, 8'b00_01_00_00, 1, 2'd2, 18'h00001);
    vecs[8]  = mk(1, 2'd2, 18'h00003, 4'b1011, 0, 4'b0100, 8'b00_10_00_00, 1, 2'd2, 18'h00001);
    // Head-of-line isolation: a accepts while c is full
    vecs[9]  = mk(1, 2'd0, 18'h3ffff, 4'b1011, 1, 4'b0100, 8'b00_10_00_00, 0, 2'd0, 18'h0);
    vecs[10] = mk(0, 2'd0, 18'h00000, 4'b1011, 1, 4'b0101, 8'b00_10_00_01, 1, 2'd0, 18'h3ffff);
    // Release c: pop on full refuses push, then push+pop at level 1
    vecs[11] = mk(1, 2'd2, 18'h00003, 4'b1111, 0, 4'b0100, 8'b00_10_00_00, 1, 2'd2, 18'h00001);
    vecs[12] = mk(1, 2'd2, 18'h00003, 4'b1111, 1, 4'b0100, 8'b00_01_00_00, 1, 2'd2, 18'h00002);
    vecs[13] = mk(0, 2'd0, 18'h00000, 4'b1111, 1, 4'b0100, 8'b00_01_00_00, 1, 2'd2, 18'h00003);
    vecs[14] = mk(0, 2'd0, 18'h00000, 4'b1111, 1, 4'b0000, 8'b00_00_00_00, 0, 2'd0, 18'h0);
    // Simultaneous push/pop on b with one entry, then with b full
    vecs[15] = mk(1, 2'd1, 18'h11111, 4'b1101, 1, 4'b0000, 8'b00_00_00_00, 0, 2'd0, 18'h0);
    vecs[16] = mk(1, 2'd1, 18'h2aaaa, 4'b1111, 1, 4'b0010, 8'b00_00_01_00, 1, 2'd1, 18'h11111);
    vecs[17] = mk(0, 2'd0, 18'h00000, 4'b1101, 1, 4'b0010, 8'b00_00_01_00, 1, 2'd1, 18'h2aaaa);
    vecs[18] = mk(1, 2'd1, 18'h22222, 4'b1101, 1, 4'b0010, 8'b00_00_01_00, 1, 2'd1, 18'h2aaaa);
    vecs[19] = mk(1, 2'd1, 18'h2aaaa, 4'b1111, 0, 4'b0010, 8'b00_00_10_00, 1, 2'd1, 18'h2aaaa);
    vecs[20] = mk(0, 2'd0, 18'h00000, 4'b1111, 1, 4'b0010, 8'b00_00_01_00, 1, 2'd1, 18'h22222);
    vecs[21] = mk(0, 2'd0, 18'h00000, 4'b1111, 1, 4'b0000, 8'b00_00_00_00, 1, 2'd1, 18'h22222);
    // in_valid=0 with junk select/data and ready on empty channels
    vecs[22] = mk(0, 2'd2, 18'h3ffff, 4'b1111, 1, 4'b0000, 8'b00_00_00_00, 0, 2'd0, 18'h0);
    vecs[23] = mk(0, 2'd0, 18'h00000, 4'b0000, 1, 4'b0000, 8'b00_00_00_00, 1, 2'd2, 18'h00003);

    rst = 1'b1;
    drive(0, 2'd0, '0, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_out_valid", -1, 72'(out_valid), 72'(4'b0000));
    chk("reset_level",     -1, 72'(level), 72'(8'h00));
    chk("reset_in_ready",  -1, 72'(in_ready), 72'(1'b1));
    chk("reset_out_data",  -1, 72'(out_data), 72'(0));

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      #1;
      chk("in_ready",  i, 72'(in_ready),  72'(vecs[i].exp_rdy));
      chk("out_valid", i, 72'(out_valid), 72'(vecs[i].exp_ov));
      chk("level",     i, 72'(level),     72'(vecs[i].exp_lvl));
      if (vecs[i].chk_d)
        chk("out_data", i, 72'(out_data[vecs[i].dch*DW +: DW]), 72'(vecs[i].dval));
      @(posedge clk);
      #1;
    end

    // Mid-operation reset: fill a and d, then reset during a push
    drive(1, 2'd0, 18'h00111, 4'b0000); @(posedge clk); #1;
    drive(1, 2'd0, 18'h00222, 4'b0000); @(posedge clk); #1;
    drive(1, 2'd3, 18'h00333, 4'b0000); @(posedge clk); #1;
    drive(1, 2'd3, 18'h00444, 4'b0000); @(posedge clk); #1;
    drive(0, 2'd0, '0, 4'b0000);
    #1;
    chk("fill_level",     100, 72'(level), 72'(8'b10_00_00_10));
    chk("fill_out_valid", 100, 72'(out_valid), 72'(4'b1001));
    chk("fill_in_ready_a", 100, 72'(in_ready), 72'(1'b0));
    chk("fill_head_d",    100, 72'(out_data[3*DW +: DW]), 72'(18'h00333));
    rst = 1'b1;
    drive(1, 2'd1, 18'h00555, 4'b1111);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 2'd0, '0, 4'b0000);
    #1;
    chk("mid_rst_level",     101, 72'(level), 72'(8'h00));
    chk("mid_rst_out_valid", 101, 72'(out_valid), 72'(4'b0000));
    chk("mid_rst_out_data",  101, 72'(out_data), 72'(0));
    chk("mid_rst_in_ready",  101, 72'(in_ready), 72'(1'b1));
    @(posedge clk); #2;
    chk("mid_rst_word_lost", 102, 72'(out_valid), 72'(4'b0000));
    chk("mid_rst_level2",    102, 72'(level), 72'(8'h00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1_to_4.md
Name: demux_1_to_4

Overview:
- Inverse of the 4-to-1 output mux: takes one 18-bit word stream and steers each word to one of four output channels (a, b, c, d) using a 2-bit select.
- Each channel has a small FIFO and its own valid/ready handshake, so a stalled consumer only blocks words addressed to it.
- Sits upstream of the four consumers that currently feed the 4-to-1 mux inputs.

Parameters:
- DATA_WIDTH, 18, width of each data word.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DATA_WIDTH  word to route.
- in_select  input  2  destination: 00 selects a, 01 selects b, 10 selects c, 11 selects d (same encoding as the 4-to-1 mux select_bit).
- in_valid  input  1  in_data and in_select are valid.
- in_ready  output  1  the selected channel can accept this cycle.
- out_data  output  4*DATA_WIDTH  head word of each channel; a = [DATA_WIDTH-1:0], then b, c, d upward.
- out_valid  output  4  per-channel head valid.
- out_ready  input  4  per-channel consumer ready.
- level  output  4*(clog2(DEPTH)+1)  per-channel occupancy, same packing order as out_data.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All FIFOs empty; all pointers zero; storage cleared to 0.
  - After reset: out_valid=0, out_data=0, level=0, in_ready=1.
  - Reset overrides any push or pop in the same cycle; in-flight words are discarded.
- in_ready is combinational and equals NOT full[in_select]. It does not depend on in_valid.
- Push: when in_valid & in_ready, in_data is written to the tail of channel in_select at the edge. Exactly one channel is written per cycle.
- Pop: for each channel i, when out_valid[i] & out_ready[i], the head is removed at the edge. All four channels may pop in the same cycle.
- out_valid[i] = NOT empty[i]. out_data slice i = head entry of channel i, registered with no combinational path from in_data.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N, i.e. visible in cycle N+1. There is no bypass from in_data to out_data.
- Per-channel order is FIFO. Across channels no ordering relation exists.
- Simultaneous push and pop on the same channel:
  - Not full: both occur and level is unchanged.
  - Full: the push is refused (in_ready=0), the pop occurs, and level decrements. There is no full-pass-through.
- Empty channel: out_ready is ignored and no underflow occurs.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from a separate count register of clog2(DEPTH)+1 bits, range 0..DEPTH.
- When in_valid=0, in_select and in_data are don't-care and must not alter state.
- out_data slice i holds its last head value when empty. Consumers must qualify it with out_valid.
- No X on any output after the first reset edge.

Decomposition:
- Shared package (demux_pkg):
  - DATA_WIDTH default 18, NUM_CH=4, SEL_WIDTH=2.
  - Channel index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3, matching the select encoding.
- One natural sub-module, channel_fifo:
  - Ports: clk, rst, push, push_data, pop, head_data, empty, full, count; parameterised by DATA_WIDTH and DEPTH.
  - The top instantiates four copies, plus the select decode and ready/valid glue.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> out_valid=4'b0000, level all 0, in_ready=1, out_data=0.
- Routing: out_ready=4'b1111; send 18'h1234 sel 00, 18'h5678 sel 01, 18'h9abc sel 10, 18'hdef0 sel 11 on consecutive cycles -> each appears on slices a, b, c, d respectively one cycle after acceptance, with out_valid pulsing for exactly one cycle per word.
- Backpressure and full: out_ready[2]=0; send 18'h00001, 18'h00002, 18'h00003 to sel 10 -> first two accepted, level c=2, in_ready=0 on the third. Raising out_ready[2] pops 18'h00001 then 18'h00002 in order; the third is accepted the cycle after full clears.
- Head-of-line isolation: with channel c full, send 18'h3ffff to sel 00 -> accepted immediately and visible on slice a next cycle.
- Simultaneous push and pop: channel b holds 1 entry with out_ready[1]=1 while pushing 18'h2aaaa to sel 01 -> level b stays 1 and the old head leaves. With b full and the same stimulus -> push refused and level drops to DEPTH-1.
- Mid-operation reset: fill channels a and d, assert rst for one cycle during a push -> all level=0, out_valid=0, and the pushed word is lost.
